l2_bank_ctrl: RTL and testbench
===============================

Name: l2_bank_ctrl

Overview:
- Parametrised controller for one L2 SRAM bank, instantiated once per interleaved bank and once per private bank.
- Handles the TCDM slave handshake, base-offset removal and word/interleave address slicing.
- Adds three things the flat per-bank wrappers lack: configurable read latency, zero-initialisation after reset, and out-of-range error reporting.

Parameters:
- NUM_WORDS, 32768, bank depth in DATA_WIDTH words; must be a power of two.
- DATA_WIDTH, 32, word width; must be a multiple of 8.
- BASE_ADDR, 32'h1C00_0000, byte address subtracted from add_i.
- INTL_BANKS, 1, number of interleaved sibling banks; must be a power of two. Use 1 for a private bank.
- LATENCY, 1, SRAM read latency in cycles; legal range 1..4.
- INIT_ON_RESET, 1, 1 = zero-fill the whole bank after reset.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- test_mode_i  in  1  skips or aborts the init sweep
- req_i  in  1  TCDM request
- add_i  in  32  byte address
- wen_i  in  1  0 = write, 1 = read
- wdata_i  in  DATA_WIDTH  write data
- be_i  in  DATA_WIDTH/8  byte enables
- gnt_o  out  1  grant
- r_valid_o  out  1  response valid
- r_rdata_o  out  DATA_WIDTH  read data
- r_opc_o  out  1  response error
- init_done_o  out  1  bank is accepting requests

Behaviour:
- Reset is asynchronous and active-low on rst_ni; the clock is clk_i.
- Reset values: gnt_o 0, r_valid_o 0, r_opc_o 0, r_rdata_o 0, init_done_o 0 if INIT_ON_RESET else 1.
- State machine: INIT -> RUN.
  - INIT is entered on reset only when INIT_ON_RESET=1; otherwise the FSM resets to RUN.
  - In INIT, a counter of width AW=$clog2(NUM_WORDS) writes zeros to address cnt every cycle with all byte enables set.
  - Leave INIT for RUN after writing address NUM_WORDS-1, or in any INIT cycle where test_mode_i=1.
  - RUN is terminal until the next reset. Reset mid-INIT restarts the counter at 0.
- Grant: gnt_o = req_i & (state==RUN), combinational. No backpressure in RUN; one request per cycle.
- Address decode:
  - off = add_i - BASE_ADDR (32-bit, wraps modulo 2^32).
  - LSB = $clog2(DATA_WIDTH/8) + $clog2(INTL_BANKS).
  - Word index = off[LSB+AW-1:LSB].
  - Range error when off[31:LSB+AW] != 0. This includes add_i < BASE_ADDR, which wraps to a large offset.
- Errored request: it is granted, but no SRAM access is made (SRAM req suppressed, so writes are dropped). Its response carries r_opc_o=1 and r_rdata_o=0.
- Response timing:
  - Every granted request, read or write, produces exactly one r_valid_o pulse LATENCY cycles after the grant cycle.
  - Valid and error flags travel in a LATENCY-deep shift register, cleared on reset.
  - r_rdata_o is SRAM data for reads, don't-care for writes, and 0 for errored requests.
  - Back-to-back requests give back-to-back responses in order.
  - r_opc_o is 0 on non-error responses.
- Init sweep accesses never produce r_valid_o.
- SRAM: tc_sram, NumWords=NUM_WORDS, NumPorts=1, Latency=LATENCY, we = ~wen_i.

Optional Feature:
- Macro: L2_BANK_PARITY_EN.
- When defined:
  - SRAM width is DATA_WIDTH + DATA_WIDTH/8, with one even-parity bit per byte.
  - Each parity bit is written under its byte's enable; the init sweep writes parity 0.
  - On a read response, any byte parity mismatch sets r_opc_o=1; data is still returned.
- When undefined: SRAM width is DATA_WIDTH, and r_opc_o reflects range errors only.

Decomposition:
- Package l2_mem_pkg holds:
  - the FSM state enum (INIT, RUN);
  - per-bank BASE_ADDR constants for the interleaved region and private banks 0..3;
  - the default depth constants;
  - a byte-parity function, used under the macro.
- One sub-module, l2_bank_resp_pipe: the LATENCY-deep valid/error shift register with async reset.

Test Plan:
- INIT_ON_RESET=1, NUM_WORDS=1024: release reset. gnt_o stays 0 for 1024 cycles with req_i=1, then init_done_o=1 and gnt_o follows req_i. A read of any address returns 32'h0.
- test_mode_i=1 at reset release: init_done_o=1 on the first clock edge after reset release.
- LATENCY=3, BASE_ADDR=32'h1C01_0000, INTL_BANKS=4:
  - Write 32'hDEADBEEF, be=4'hF, add=32'h1C01_0010, which maps to word 1.
  - Read the same address: r_valid_o exactly 3 cycles after the grant, r_rdata_o=32'hDEADBEEF.
  - Four back-to-back reads give four consecutive valids.
- Partial write be=4'b0010, wdata=32'h0000_AB00 over 32'hDEADBEEF: readback is 32'hDEADABEF.
- Range errors:
  - add=BASE_ADDR + NUM_WORDS*4*INTL_BANKS: granted, r_opc_o=1, r_rdata_o=0, memory unchanged.
  - add=BASE_ADDR-4: same result.
- Reset asserted mid-INIT (cycle 500) and mid-read: r_valid_o drops to 0 immediately. After release, the sweep restarts from 0 (1024 cycles). With L2_BANK_PARITY_EN, a forced parity-bit flip gives r_opc_o=1 on read.

Source files
------------

// File: rtl/l2_mem_pkg.sv
// l2_mem_pkg: shared FSM encoding, L2 address map, default bank geometry and parity helper.
package l2_mem_pkg;

    typedef enum logic [0:0] {
        L2_INIT = 1'b0,
        L2_RUN  = 1'b1
    } l2_state_e;

    localparam logic [0:0] ST_INIT = L2_INIT;
    localparam logic [0:0] ST_RUN  = L2_RUN;

    localparam int unsigned L2_DEF_NUM_WORDS  = 32768;
    localparam int unsigned L2_DEF_DATA_WIDTH = 32;

    localparam logic [31:0] L2_PRIV0_BASE = 32'h1C00_0000;
    localparam logic [31:0] L2_PRIV1_BASE = 32'h1C02_0000;
    localparam logic [31:0] L2_PRIV2_BASE = 32'h1C04_0000;
    localparam logic [31:0] L2_PRIV3_BASE = 32'h1C06_0000;
    localparam logic [31:0] L2_INTL_BASE  = 32'h1C08_0000;

    function automatic logic byte_par(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/l2_bank_resp_pipe.sv
// l2_bank_resp_pipe: LATENCY-deep valid/tag shift register that lines responses up with SRAM read data.
module l2_bank_resp_pipe #(
    parameter int unsigned LATENCY = 1,
    parameter int unsigned TW      = 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          valid_i,
    input  logic [TW-1:0] tag_i,
    output logic          valid_o,
    output logic [TW-1:0] tag_o
);

    logic [LATENCY-1:0]         v_q;
    logic [LATENCY-1:0][TW-1:0] t_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            v_q <= '0;
            t_q <= '0;
        end else begin
            v_q[0] <= valid_i;
            t_q[0] <= tag_i;
            for (int i = 1; i < LATENCY; i++) begin
                v_q[i] <= v_q[i-1];
                t_q[i] <= t_q[i-1];
            end
        end
    end

    assign valid_o = v_q[LATENCY-1];
    assign tag_o   = t_q[LATENCY-1];

endmodule

// File: rtl/tc_sram.sv
// tc_sram: behavioural multi-port SRAM with per-lane byte enables and configurable read latency.
module tc_sram #(
    parameter int unsigned NumWords  = 1024,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned ByteWidth = 8,
    parameter int unsigned NumPorts  = 1,
    parameter int unsigned Latency   = 1,
    parameter int unsigned AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1,
    parameter int unsigned BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic [NumPorts-1:0]                  req_i,
    input  logic [NumPorts-1:0]                  we_i,
    input  logic [NumPorts-1:0][AddrWidth-1:0]   addr_i,
    input  logic [NumPorts-1:0][DataWidth-1:0]   wdata_i,
    input  logic [NumPorts-1:0][BeWidth-1:0]     be_i,
    output logic [NumPorts-1:0][DataWidth-1:0]   rdata_o
);

    logic [DataWidth-1:0] sram [NumWords];
    logic [NumPorts-1:0][Latency-1:0][DataWidth-1:0] rd_q;

    always_ff @(posedge clk_i) begin
        for (int p = 0; p < NumPorts; p++) begin
            if (req_i[p] && we_i[p]) begin
                for (int j = 0; j < DataWidth; j++) begin
                    if (be_i[p][j / ByteWidth]) sram[addr_i[p]][j] <= wdata_i[p][j];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_q <= '0;
        end else begin
            for (int p = 0; p < NumPorts; p++) begin
                if (req_i[p] && !we_i[p]) rd_q[p][0] <= sram[addr_i[p]];
                for (int i = 1; i < Latency; i++) rd_q[p][i] <= rd_q[p][i-1];
            end
        end
    end

    always_comb begin
        for (int p = 0; p < NumPorts; p++) rdata_o[p] = rd_q[p][Latency-1];
    end

endmodule

// File: rtl/l2_bank_ctrl.sv
// l2_bank_ctrl: one L2 SRAM bank behind a TCDM slave port with zero-fill after reset,
// range-error responses and configurable latency; L2_BANK_PARITY_EN adds per-byte even parity.
module l2_bank_ctrl
    import l2_mem_pkg::*;
#(
    parameter int unsigned NUM_WORDS     = L2_DEF_NUM_WORDS,
    parameter int unsigned DATA_WIDTH    = L2_DEF_DATA_WIDTH,
    parameter logic [31:0] BASE_ADDR     = L2_PRIV0_BASE,
    parameter int unsigned INTL_BANKS    = 1,
    parameter int unsigned LATENCY       = 1,
    parameter bit          INIT_ON_RESET = 1'b1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    test_mode_i,
    input  logic                    req_i,
    input  logic [31:0]             add_i,
    input  logic                    wen_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    input  logic [DATA_WIDTH/8-1:0] be_i,
    output logic                    gnt_o,
    output logic                    r_valid_o,
    output logic [DATA_WIDTH-1:0]   r_rdata_o,
    output logic                    r_opc_o,
    output logic                    init_done_o
);

    localparam int unsigned AW  = $clog2(NUM_WORDS);
    localparam int unsigned BW  = DATA_WIDTH / 8;
    localparam int unsigned LSB = $clog2(BW) + $clog2(INTL_BANKS);
`ifdef L2_BANK_PARITY_EN
    localparam int unsigned LW  = 9;
    localparam int unsigned TW  = 2;
`else
    localparam int unsigned LW  = 8;
    localparam int unsigned TW  = 1;
`endif
    localparam int unsigned SW  = BW * LW;

    logic [0:0]            state_q, state_d;
    logic [AW-1:0]         cnt_q, cnt_d;
    logic                  run, err, opc;
    logic [31:0]           off, off_sh;
    logic                  sram_req, sram_we;
    logic [AW-1:0]         sram_addr;
    logic [SW-1:0]         sram_wdata, sram_rdata;
    logic [BW-1:0]         sram_be;
    logic [DATA_WIDTH-1:0] rdata;
    logic [TW-1:0]         tag, rsp_tag;
    logic                  rsp_valid;

    assign run         = state_q == ST_RUN;
    assign gnt_o       = req_i & run;
    assign init_done_o = run;

    // Anything above the bank's word field, including a wrapped negative offset, is out of range.
    assign off    = add_i - BASE_ADDR;
    assign off_sh = off >> LSB;
    assign err    = |(off_sh >> AW);

    always_comb begin
        state_d = (!run && (test_mode_i || cnt_q == AW'(NUM_WORDS - 1))) ? ST_RUN : state_q;
        cnt_d   = run ? cnt_q : cnt_q + AW'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= INIT_ON_RESET ? ST_INIT : ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign sram_req  = run ? req_i & ~err : 1'b1;
    assign sram_we   = run ? ~wen_i : 1'b1;
    assign sram_addr = run ? off_sh[AW-1:0] : cnt_q;
    assign sram_be   = run ? be_i : '1;

`ifdef L2_BANK_PARITY_EN
    logic [BW-1:0] par_bad;

    for (genvar b = 0; b < BW; b++) begin : g_lane
        assign sram_wdata[b*LW +: LW] = run ? {byte_par(wdata_i[b*8 +: 8]), wdata_i[b*8 +: 8]} : '0;
        assign rdata[b*8 +: 8]        = sram_rdata[b*LW +: 8];
        assign par_bad[b]             = sram_rdata[b*LW + 8] ^ byte_par(sram_rdata[b*LW +: 8]);
    end

    assign tag = {wen_i, err};
    assign opc = rsp_tag[0] | (rsp_tag[1] & |par_bad);
`else
    assign sram_wdata = run ? wdata_i : '0;
    assign rdata      = sram_rdata;
    assign tag        = err;
    assign opc        = rsp_tag[0];
`endif

    tc_sram #(
        .NumWords  (NUM_WORDS),
        .DataWidth (SW),
        .ByteWidth (LW),
        .NumPorts  (1),
        .Latency   (LATENCY)
    ) i_sram (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .req_i   (sram_req),
        .we_i    (sram_we),
        .addr_i  (sram_addr),
        .wdata_i (sram_wdata),
        .be_i    (sram_be),
        .rdata_o (sram_rdata)
    );

    l2_bank_resp_pipe #(
        .LATENCY (LATENCY),
        .TW      (TW)
    ) i_resp_pipe (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .valid_i (gnt_o),
        .tag_i   (tag),
        .valid_o (rsp_valid),
        .tag_o   (rsp_tag)
    );

    assign r_valid_o = rsp_valid;
    assign r_opc_o   = rsp_valid & opc;
    assign r_rdata_o = (rsp_valid & ~rsp_tag[0]) ? rdata : '0;

endmodule

// File: tb/tb_l2_bank_ctrl.sv
// tb_l2_bank_ctrl: directed test of l2_bank_ctrl against a word-array/response-queue model.
`timescale 1ns/1ps
module tb_l2_bank_ctrl;

    localparam int          NW    = 1024;
    localparam int          LAT   = 3;
    localparam logic [31:0] BASE  = 32'h1C01_0000;
    localparam logic [31:0] BASE1 = 32'h1C00_0000;

    logic        clk = 1'b0, rst_n = 1'b0, tm = 1'b0;
    logic        req = 1'b0, wen = 1'b1;
    logic [31:0] add = '0, wdata = '0;
    logic [3:0]  be = '0;
    logic        gnt, rv, opc, done;
    logic [31:0] rdata;
    logic        req1 = 1'b0, wen1 = 1'b1;
    logic [31:0] add1 = '0, wdata1 = '0;
    logic [3:0]  be1 = '0;
    logic        gnt1, rv1, opc1, done1;
    logic [31:0] rdata1;
    int          total = 0, bad = 0;

    always #5 clk = ~clk;

    l2_bank_ctrl #(.NUM_WORDS(NW), .DATA_WIDTH(32), .BASE_ADDR(BASE), .INTL_BANKS(4),
                   .LATENCY(LAT), .INIT_ON_RESET(1'b1)) dut (
        .clk_i(clk), .rst_ni(rst_n), .test_mode_i(tm), .req_i(req), .add_i(add), .wen_i(wen),
        .wdata_i(wdata), .be_i(be), .gnt_o(gnt), .r_valid_o(rv), .r_rdata_o(rdata),
        .r_opc_o(opc), .init_done_o(done));

    l2_bank_ctrl #(.NUM_WORDS(256), .DATA_WIDTH(32), .BASE_ADDR(BASE1), .INTL_BANKS(1),
                   .LATENCY(1), .INIT_ON_RESET(1'b0)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .test_mode_i(1'b0), .req_i(req1), .add_i(add1), .wen_i(wen1),
        .wdata_i(wdata1), .be_i(be1), .gnt_o(gnt1), .r_valid_o(rv1), .r_rdata_o(rdata1),
        .r_opc_o(opc1), .init_done_o(done1));

    typedef struct {
        longint      due;
        logic [31:0] data;
        bit          chk;
        bit          opc;
    } rsp_t;

    rsp_t        q[$];
    logic [31:0] mem [NW];
    bit          known [NW];
    bit          pbad [NW];
    bit          run_m = 1'b0;
    int          cnt_m = 0;
    longint      cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic model_req();
        logic [31:0] off;
        int          idx;
        rsp_t        r;
        off    = add - BASE;
        idx    = int'((off >> 4) & (NW - 1));
        r.due  = cyc + LAT - 1;
        r.opc  = (off >> 4) >= NW;
        r.chk  = 1'b1;
        r.data = '0;
        if (!r.opc && !wen) begin
            for (int b = 0; b < 4; b++) if (be[b]) mem[idx][8*b +: 8] = wdata[8*b +: 8];
            known[idx] = known[idx] || (be == 4'hF);
            if (be[0]) pbad[idx] = 1'b0;
            r.chk = 1'b0;
        end else if (!r.opc) begin
            r.data = mem[idx];
            r.chk  = known[idx];
            r.opc  = pbad[idx];
        end
        q.push_back(r);
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            run_m = 1'b0;
            cnt_m = 0;
            q.delete();
        end else begin
            cyc++;
            if (run_m && req) begin
                model_req();
            end else if (!run_m) begin
                mem[cnt_m]   = '0;
                known[cnt_m] = 1'b1;
                pbad[cnt_m]  = 1'b0;
                if (tm || cnt_m == NW - 1) run_m = 1'b1;
                cnt_m++;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            check("rst_gnt", gnt, 0);
            check("rst_valid", rv, 0);
            check("rst_opc", opc, 0);
            check("rst_rdata", rdata, 0);
            check("rst_init_done", done, 0);
        end else begin
            check("gnt", gnt, req & run_m);
            check("init_done", done, run_m);
            if (q.size() > 0 && q[0].due == cyc) begin
                check("r_valid", rv, 1);
                check("r_opc", opc, q[0].opc);
                if (q[0].chk) check("r_rdata", rdata, q[0].data);
                void'(q.pop_front());
            end else begin
                check("r_valid", rv, 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        req = 1'b1; wen = w; add = a; wdata = d; be = b;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        drive(1'b0, a, d, b);
        #1 check("wr_gnt", gnt, 1);
        tick();
        req = 1'b0;
        repeat (LAT) tick();
    endtask

    task automatic rd_check(input string name, input logic [31:0] a, input logic [31:0] ed, input logic eo);
        int n;
        drive(1'b1, a, '0, '0);
        #1 check({name, "_gnt"}, gnt, 1);
        tick();
        req = 1'b0;
        n = 1;
        while (!rv && n < 10) begin
            tick();
            n++;
        end
        check({name, "_lat"}, 32'(n), 32'(LAT));
        check({name, "_data"}, rdata, ed);
        check({name, "_opc"}, opc, eo);
    endtask

    task automatic init_count(input int exp);
        int n = 0;
        while (!done && n < 3000) begin
            tick();
            n++;
        end
        check("init_cycles", 32'(n), 32'(exp));
    endtask

    initial begin
        int nv = 0, first = -1, last = -1;
        req = 1'b1; wen = 1'b1; add = BASE;
        repeat (3) tick();
        check("lit_rst_done", done, 0);
        check("lit_rst_gnt", gnt, 0);
        check("lit_rst_done1", done1, 1);
        tm = 1'b1; rst_n = 1'b1;
        tick();
        check("tm_done", done, 1);
        tm = 1'b0; req = 1'b0;
        repeat (LAT + 2) tick();

        req1 = 1'b1; wen1 = 1'b0; add1 = BASE1 + 32'h8; wdata1 = 32'hA5A5_1234; be1 = 4'hF;
        #1 check("d1_gnt", gnt1, 1);
        tick();
        wen1 = 1'b1;
        tick();
        check("d1_valid", rv1, 1);
        check("d1_rdata", rdata1, 32'hA5A5_1234);
        check("d1_opc", opc1, 0);
        add1 = BASE1 + 32'h400;
        tick();
        check("d1_err_hi_valid", rv1, 1);
        check("d1_err_hi_opc", opc1, 1);
        check("d1_err_hi_rdata", rdata1, 0);
        add1 = BASE1 - 32'h4;
        tick();
        req1 = 1'b0;
        check("d1_err_lo_opc", opc1, 1);
        check("d1_err_lo_rdata", rdata1, 0);
        tick();

        rst_n = 1'b0;
        tick();
        req = 1'b1; wen = 1'b1; add = BASE; rst_n = 1'b1;
        repeat (500) tick();
        check("mid_init_done", done, 0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        init_count(NW);
        req = 1'b0;
        repeat (LAT + 2) tick();

        rd_check("rd_zero", BASE + 32'h50, 32'h0, 1'b0);
        wr(BASE + 32'h10, 32'hDEAD_BEEF, 4'hF);
        rd_check("rd_full", BASE + 32'h10, 32'hDEAD_BEEF, 1'b0);
        wr(BASE + 32'h10, 32'h0000_AB00, 4'b0010);
        rd_check("rd_part", BASE + 32'h10, 32'hDEAD_ABEF, 1'b0);

        wr(BASE + 32'h20, 32'h1111_2222, 4'hF);
        for (int n = 0; n < 10; n++) begin
            req = n < 4; wen = 1'b1;
            add = n[0] ? BASE + 32'h20 : BASE + 32'h10;
            tick();
            if (rv) begin
                nv++;
                if (first < 0) first = n;
                last = n;
            end
        end
        req = 1'b0;
        check("b2b_count", 32'(nv), 32'd4);
        check("b2b_first", 32'(first), 32'(LAT - 1));
        check("b2b_span", 32'(last - first), 32'd3);

        wr(BASE + 32'h4000, 32'h1234_5678, 4'hF);
        rd_check("err_hi", BASE + 32'h4000, 32'h0, 1'b1);
        rd_check("err_hi_mem", BASE, 32'h0, 1'b0);
        wr(BASE - 32'h4, 32'h5555_AAAA, 4'hF);
        rd_check("err_lo", BASE - 32'h4, 32'h0, 1'b1);
        rd_check("err_lo_mem", BASE + 32'h3FF0, 32'h0, 1'b0);

`ifdef L2_BANK_PARITY_EN
        dut.i_sram.sram[1][8] = ~dut.i_sram.sram[1][8];
        pbad[1] = 1'b1;
        rd_check("par_err", BASE + 32'h10, 32'hDEAD_ABEF, 1'b1);
`endif

        drive(1'b1, BASE + 32'h10, '0, '0);
        tick();
        req = 1'b0;
        tick();
        check("pre_rst_valid", rv, 0);
        tick();
        check("mid_rd_valid", rv, 1);
        rst_n = 1'b0;
        #1;
        check("rst_valid_drop", rv, 0);
        check("rst_rdata_drop", rdata, 0);
        tick();
        req = 1'b1; wen = 1'b1; add = BASE; rst_n = 1'b1;
        init_count(NW);
        req = 1'b0;
        repeat (LAT + 2) tick();
        rd_check("post_sweep", BASE + 32'h10, 32'h0, 1'b0);

        repeat (2) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
